// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM host-port arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitDone
    } arb_state_e;

    localparam int unsigned DefAddrW         = 24;
    localparam int unsigned DefDataW         = 16;
    localparam int unsigned DefTimeoutCycles = 1024;

endpackage

// File: rtl/sdram_host_arbiter_if.sv
// Requester and controller-side bus of the SDRAM host-port arbiter.
// rsp_err exists only when SDRAM_ARB_TIMEOUT_EN is defined.
interface sdram_host_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned DATA_W    = DefDataW
);
    localparam int unsigned IdxW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_we;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS-1:0]        rsp_valid;
    logic [DATA_W-1:0]           rsp_rdata;
`ifdef SDRAM_ARB_TIMEOUT_EN
    logic                        rsp_err;
`endif
    logic [IdxW-1:0]             cur_port;
    logic                        arb_idle;
    logic [ADDR_W-1:0]           ctl_wr_addr;
    logic [DATA_W-1:0]           ctl_wr_data;
    logic                        ctl_rd_enable;
    logic                        ctl_wr_enable;
    logic                        ctl_busy;
    logic [DATA_W-1:0]           ctl_rd_data;
    logic                        ctl_rd_ready;

    // Arbiter side.
    modport slave (
`ifdef SDRAM_ARB_TIMEOUT_EN
        output rsp_err,
`endif
        input  req_valid, req_we, req_addr, req_wdata, ctl_busy, ctl_rd_data, ctl_rd_ready,
        output req_ready, rsp_valid, rsp_rdata, cur_port, arb_idle,
        output ctl_wr_addr, ctl_wr_data, ctl_rd_enable, ctl_wr_enable
    );

    // Requesters plus controller side.
    modport master (
`ifdef SDRAM_ARB_TIMEOUT_EN
        input  rsp_err,
`endif
        output req_valid, req_we, req_addr, req_wdata, ctl_busy, ctl_rd_data, ctl_rd_ready,
        input  req_ready, rsp_valid, rsp_rdata, cur_port, arb_idle,
        input  ctl_wr_addr, ctl_wr_data, ctl_rd_enable, ctl_wr_enable
    );

endinterface

// File: rtl/sdram_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module sdram_arb_rr_pick #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]     idx
);

    always_comb begin
        logic        found;
        int unsigned j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            j = (32'(ptr) + i) % NUM_PORTS;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/sdram_host_arbiter.sv
// Round-robin arbiter sharing one sdram_controller host port between NUM_PORTS requesters.
// Define SDRAM_ARB_TIMEOUT_EN to add the watchdog and the rsp_err output.
module sdram_host_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = 4,
    parameter int unsigned ADDR_W         = DefAddrW,
    parameter int unsigned DATA_W         = DefDataW,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input logic                 clk,
    input logic                 rst,
    sdram_host_arbiter_if.slave bus
);

    localparam int unsigned IdxW = $clog2(NUM_PORTS);

    if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_param
        $error("sdram_host_arbiter: unsupported parameter value");
    end

    arb_state_e           state_q, state_d;
    logic [IdxW-1:0]      ptr_q, ptr_d, cur_q, cur_d, pick_idx;
    logic [NUM_PORTS-1:0] pick_gnt;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d, rdcap_q, rdcap_d, rdata_q, rdata_d, cpl_data;
    logic                 we_q, we_d, rd_seen_q, rd_seen_d;
    logic                 grant, done, timeout;

    sdram_arb_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IdxW)
    ) u_pick (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cur_d     = cur_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rd_seen_d = rd_seen_q;
        rdcap_d   = rdcap_q;
        rdata_d   = rdata_q;
        grant     = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        cpl_data  = '0;

        unique case (state_q)
            StIdle: begin
                if (|bus.req_valid && !bus.ctl_busy && !rst) begin
                    grant     = 1'b1;
                    cur_d     = pick_idx;
                    ptr_d     = (pick_idx == IdxW'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
                    addr_d    = bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    wdata_d   = bus.req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                    we_d      = bus.req_we[pick_idx];
                    rd_seen_d = 1'b0;
                    rdcap_d   = '0;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                if (bus.ctl_busy) state_d = StWaitDone;
            end
            StWaitDone: begin
                if (we_q) begin
                    done = !bus.ctl_busy;
                end else begin
                    if (bus.ctl_rd_ready) begin
                        rd_seen_d = 1'b1;
                        rdcap_d   = bus.ctl_rd_data;
                    end
                    // Read data arriving on the completing cycle is forwarded directly.
                    done     = (rd_seen_q || bus.ctl_rd_ready) && !bus.ctl_busy;
                    cpl_data = bus.ctl_rd_ready ? bus.ctl_rd_data : rdcap_q;
                end
                if (done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

`ifdef SDRAM_ARB_TIMEOUT_EN
        cnt_d = cnt_q;
        if (grant) begin
            cnt_d = '0;
        end else if (state_q != StIdle) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(TIMEOUT_CYCLES)) begin
                timeout  = 1'b1;
                done     = 1'b0;
                cpl_data = '0;
                state_d  = StIdle;
            end
        end
`endif

        if (done || timeout) rdata_d = cpl_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            cur_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rd_seen_q <= 1'b0;
            rdcap_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cur_q     <= cur_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            rd_seen_q <= rd_seen_d;
            rdcap_q   <= rdcap_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.req_ready     = grant ? pick_gnt : '0;
    assign bus.rsp_valid     = (done || timeout) ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << cur_q) : '0;
    assign bus.rsp_rdata     = (done || timeout) ? cpl_data : rdata_q;
    assign bus.cur_port      = cur_q;
    assign bus.arb_idle      = (state_q == StIdle);
    assign bus.ctl_wr_addr   = addr_q;
    assign bus.ctl_wr_data   = wdata_q;
    assign bus.ctl_wr_enable = (state_q == StIssue) && we_q && !timeout;
    assign bus.ctl_rd_enable = (state_q == StIssue) && !we_q && !timeout;
`ifdef SDRAM_ARB_TIMEOUT_EN
    assign bus.rsp_err       = timeout;
`endif

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Directed self-checking bench for sdram_host_arbiter; covers SDRAM_ARB_TIMEOUT_EN when defined.
module tb_sdram_host_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errs   = 0;

    always #5 clk = ~clk;

    sdram_host_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_host_arbiter #(
        .NUM_PORTS      (NP),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic req(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
        bus.req_valid[p]           = 1'b1;
        bus.req_we[p]              = we;
        bus.req_addr[p*AW +: AW]   = a;
        bus.req_wdata[p*DW +: DW]  = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        bus.req_valid    = '0;
        bus.req_we       = '0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.ctl_busy     = 1'b0;
        bus.ctl_rd_data  = '0;
        bus.ctl_rd_ready = 1'b0;

        // Reset state
        cyc(); cyc(); settle();
        check("rst_idle",   bus.arb_idle, 1'b1);
        check("rst_en",     {bus.ctl_wr_enable, bus.ctl_rd_enable}, 2'b00);
        check("rst_ready",  bus.req_ready, 4'b0000);
        check("rst_rsp",    bus.rsp_valid, 4'b0000);
        check("rst_port",   bus.cur_port, 2'd0);
        check("rst_addr",   bus.ctl_wr_addr, 24'h0);
        check("rst_wdata",  bus.ctl_wr_data, 16'h0);
        check("rst_rdata",  bus.rsp_rdata, 16'h0);

        // Single write from port 0
        cyc(); rst = 1'b0;
        req(0, 1'b1, 24'hfedbed, 16'd3333); settle();
        check("wr_ready", bus.req_ready, 4'b0001);
        cyc(); bus.req_valid = '0; settle();
        check("wr_en",       {bus.ctl_wr_enable, bus.ctl_rd_enable}, 2'b10);
        check("wr_addr",     bus.ctl_wr_addr, 24'hfedbed);
        check("wr_data",     bus.ctl_wr_data, 16'd3333);
        check("wr_one_pulse", bus.req_ready, 4'b0000);
        check("wr_port",     bus.cur_port, 2'd0);
        cyc(); bus.ctl_busy = 1'b1; settle();
        check("wr_en_hold",  bus.ctl_wr_enable, 1'b1);
        cyc(); settle();
        check("wr_en_drop",  {bus.ctl_wr_enable, bus.ctl_rd_enable}, 2'b00);
        check("wr_no_rsp",   bus.rsp_valid, 4'b0000);
        check("wr_addr_hold", bus.ctl_wr_addr, 24'hfedbed);
        cyc(); bus.ctl_busy = 1'b0; settle();
        check("wr_rsp",      bus.rsp_valid, 4'b0001);
        check("wr_rdata",    bus.rsp_rdata, 16'h0);
`ifdef SDRAM_ARB_TIMEOUT_EN
        check("wr_err",      bus.rsp_err, 1'b0);
`endif
        cyc(); settle();
        check("wr_back_idle", bus.arb_idle, 1'b1);
        check("wr_rsp_pulse", bus.rsp_valid, 4'b0000);

        // Single read from port 2, data one cycle before busy falls
        req(2, 1'b0, 24'hbedfed, 16'h0); settle();
        check("rd_ready", bus.req_ready, 4'b0100);
        cyc(); bus.req_valid = '0; settle();
        check("rd_en",    {bus.ctl_wr_enable, bus.ctl_rd_enable}, 2'b01);
        check("rd_addr",  bus.ctl_wr_addr, 24'hbedfed);
        check("rd_port",  bus.cur_port, 2'd2);
        bus.ctl_busy = 1'b1;
        cyc(); settle();
        check("rd_en_drop", {bus.ctl_wr_enable, bus.ctl_rd_enable}, 2'b00);
        cyc(); bus.ctl_rd_ready = 1'b1; bus.ctl_rd_data = 16'hbbbb; settle();
        check("rd_wait_busy", bus.rsp_valid, 4'b0000);
        cyc(); bus.ctl_rd_ready = 1'b0; bus.ctl_rd_data = 16'h0; bus.ctl_busy = 1'b0; settle();
        check("rd_rsp",   bus.rsp_valid, 4'b0100);
        check("rd_rdata", bus.rsp_rdata, 16'hbbbb);
        cyc(); settle();
        check("rd_rdata_hold", bus.rsp_rdata, 16'hbbbb);
        check("rd_no_wr_en", bus.ctl_wr_enable, 1'b0);

        // Fairness from a fresh pointer with all ports requesting
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int p = 0; p < int'(NP); p++) req(p, 1'b1, AW'(p), DW'(p));
        for (int k = 0; k < 5; k++) begin
            logic [NP-1:0] exp_oh;
            exp_oh = '0;
            exp_oh[k % NP] = 1'b1;
            settle();
            check($sformatf("fair_grant%0d", k), bus.req_ready, exp_oh);
            cyc(); bus.ctl_busy = 1'b1; settle();
            check($sformatf("fair_port%0d", k), bus.cur_port, 2'(k % NP));
            cyc(); bus.ctl_busy = 1'b0; settle();
            check($sformatf("fair_rsp%0d", k), bus.rsp_valid, exp_oh);
            cyc();
        end
        bus.req_valid = '0;

        // Busy gating in IDLE
        bus.ctl_busy = 1'b1;
        req(1, 1'b1, 24'h000111, 16'h0111);
        for (int k = 0; k < 3; k++) begin
            settle();
            check($sformatf("gate_hold%0d", k), bus.req_ready, 4'b0000);
            cyc();
        end
        bus.ctl_busy = 1'b0; settle();
        check("gate_grant", bus.req_ready, 4'b0010);
        cyc(); bus.req_valid = '0; bus.ctl_busy = 1'b1;
        cyc(); bus.ctl_busy = 1'b0; settle();
        check("gate_rsp", bus.rsp_valid, 4'b0010);
        cyc();

        // Reset during WAIT_DONE of a read
        req(3, 1'b0, 24'h333333, 16'h0); settle();
        check("rr_ready", bus.req_ready, 4'b1000);
        cyc(); bus.req_valid = '0; bus.ctl_busy = 1'b1; settle();
        check("rr_rd_en", bus.ctl_rd_enable, 1'b1);
        cyc(); settle();
        check("rr_busy", bus.arb_idle, 1'b0);
        #2 rst = 1'b1; #1;
        check("rr_en",   {bus.ctl_wr_enable, bus.ctl_rd_enable}, 2'b00);
        check("rr_idle", bus.arb_idle, 1'b1);
        check("rr_rsp",  bus.rsp_valid, 4'b0000);
        check("rr_port", bus.cur_port, 2'd0);
        cyc(); bus.ctl_busy = 1'b0; rst = 1'b0;
        req(3, 1'b0, 24'h333333, 16'h0); settle();
        check("rr_regrant", bus.req_ready, 4'b1000);
        cyc(); bus.req_valid = '0; bus.ctl_busy = 1'b1;
        cyc(); bus.ctl_busy = 1'b0; bus.ctl_rd_ready = 1'b1; bus.ctl_rd_data = 16'h1234; settle();
        check("rr_rsp_same", bus.rsp_valid, 4'b1000);
        check("rr_rdata",    bus.rsp_rdata, 16'h1234);
        cyc(); bus.ctl_rd_ready = 1'b0; bus.ctl_rd_data = 16'h0; settle();
        check("rr_rdata_hold", bus.rsp_rdata, 16'h1234);

`ifdef SDRAM_ARB_TIMEOUT_EN
        // Controller never raises busy: 16 counted cycles, then error completion
        begin
            int  en_cycles;
            bit  seen;
            en_cycles = 0;
            seen      = 1'b0;
            req(0, 1'b1, 24'h0000aa, 16'h00aa); settle();
            check("to_ready", bus.req_ready, 4'b0001);
            cyc(); bus.req_valid = '0;
            for (int k = 0; k < 40 && !seen; k++) begin
                settle();
                if (bus.rsp_valid != '0) begin
                    seen = 1'b1;
                end else begin
                    if (bus.ctl_wr_enable) en_cycles++;
                    cyc();
                end
            end
            check("to_seen",   seen, 1'b1);
            check("to_cycles", en_cycles, 16);
            check("to_rsp",    bus.rsp_valid, 4'b0001);
            check("to_err",    bus.rsp_err, 1'b1);
            check("to_rdata",  bus.rsp_rdata, 16'h0);
            check("to_en",     {bus.ctl_wr_enable, bus.ctl_rd_enable}, 2'b00);
            cyc(); settle();
            check("to_idle",   bus.arb_idle, 1'b1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_host_arbiter.md
Name: sdram_host_arbiter

Overview:
- Round-robin arbiter that shares the single sdram_controller host port (wr_addr/wr_data/rd_enable/wr_enable/busy/rd_data/rd_ready) between NUM_PORTS requesters.
- Accepts one read or write command at a time, drives the controller's enable until the controller raises busy, then waits for completion.
- Returns one response pulse to the originating port for every accepted command.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8).
- ADDR_W, 24, host address width; matches controller wr_addr.
- DATA_W, 16, data width; matches controller wr_data/rd_data.
- TIMEOUT_CYCLES, 1024, watchdog limit. Used only when SDRAM_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_PORTS  per-port command valid.
- req_we  in  NUM_PORTS  per-port command type: 1 = write, 0 = read.
- req_addr  in  NUM_PORTS*ADDR_W  per-port address; port i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*DATA_W  per-port write data, sliced the same way.
- req_ready  out  NUM_PORTS  one-hot accept pulse.
- rsp_valid  out  NUM_PORTS  one-hot completion pulse.
- rsp_rdata  out  DATA_W  read data; valid with any rsp_valid bit.
- cur_port  out  $clog2(NUM_PORTS)  index of the port currently being served.
- arb_idle  out  1  high when the arbiter is in IDLE.
- ctl_wr_addr  out  ADDR_W  address to controller.
- ctl_wr_data  out  DATA_W  write data to controller.
- ctl_rd_enable  out  1  read request to controller.
- ctl_wr_enable  out  1  write request to controller.
- ctl_busy  in  1  controller busy.
- ctl_rd_data  in  DATA_W  controller read data.
- ctl_rd_ready  in  1  controller read data valid.

Behaviour:
- Reset values:
  - State IDLE; round-robin pointer 0.
  - All outputs 0, except arb_idle = 1.
  - Latched addr/data/we registers cleared.
  - Reset mid-operation abandons the command: enables drop asynchronously and no rsp_valid is produced.
- States:
  - IDLE:
    - If any req_valid is set and ctl_busy = 0, select the first requesting port at or after the pointer, wrapping modulo NUM_PORTS.
    - Pulse req_ready[sel] for exactly that cycle.
    - Latch addr, wdata and we into ctl_wr_addr, ctl_wr_data and an internal register.
    - Set cur_port = sel and pointer = sel+1 (wraps).
    - Go to ISSUE.
    - If ctl_busy = 1, wait in IDLE.
  - ISSUE:
    - Assert ctl_wr_enable (we = 1) or ctl_rd_enable (we = 0).
    - Hold it until the first cycle ctl_busy = 1 is sampled, then deassert next cycle and go to WAIT_DONE.
  - WAIT_DONE, write: when ctl_busy = 0, pulse rsp_valid[cur_port] with rsp_rdata = 0 and go to IDLE.
  - WAIT_DONE, read:
    - Capture ctl_rd_data into rsp_rdata on ctl_rd_ready.
    - Once rd_ready has been seen and ctl_busy = 0, pulse rsp_valid[cur_port] and go to IDLE.
    - If rd_ready and busy-low coincide, complete on that cycle.
- Latency and throughput:
  - Accept to enable assertion is 1 cycle.
  - After rsp_valid, a new grant is possible the following cycle; the minimum gap between grants is 3 cycles plus controller time.
- Requester rules:
  - A requester holds req_valid/req_we/req_addr/req_wdata stable until req_ready.
  - Inputs are ignored outside IDLE.
  - A port may re-request in the same cycle its rsp_valid pulses; that request is considered next IDLE cycle.
- Only one of ctl_rd_enable / ctl_wr_enable is ever high.
- ctl_wr_addr and ctl_wr_data stay stable from accept until return to IDLE.
- rsp_rdata holds its value until the next completion.

Optional Feature:
- SDRAM_ARB_TIMEOUT_EN defined:
  - Adds output port rsp_err (1 bit) and a cycle counter cleared on every grant, counting in ISSUE and WAIT_DONE.
  - When the counter reaches TIMEOUT_CYCLES: drop both enables, pulse rsp_valid[cur_port] with rsp_err = 1 and rsp_rdata = 0, and return to IDLE.
  - rsp_err is 0 on normal completions.
- Not defined: no counter and no rsp_err port; ISSUE and WAIT_DONE wait indefinitely.

Decomposition:
- Package sdram_arb_pkg holds:
  - State enumeration: IDLE, ISSUE, WAIT_DONE.
  - Default widths ADDR_W = 24 and DATA_W = 16.
  - Timeout default.
- Sub-module sdram_arb_rr_pick: combinational round-robin picker. Inputs are the request vector and pointer; outputs are a one-hot grant and an index.

Test Plan:
- Single write: port 0 requests write addr 24'hfedbed, data 16'd3333 → req_ready[0] pulse; ctl_wr_enable high from the next cycle until busy is seen; ctl_wr_addr = fedbed; rsp_valid[0] once busy falls; rsp_rdata = 0.
- Single read: port 2 requests read addr 24'hbedfed; controller returns 16'hbbbb on rd_ready → rsp_valid[2] with rsp_rdata = bbbb; ctl_wr_enable never asserted.
- Fairness: ports 0..3 all hold valid continuously → grant order 0, 1, 2, 3, 0; no port is granted twice before the others.
- Busy gating: ctl_busy held high in IDLE while port 1 requests → no req_ready until busy drops, then grant on the first cycle it is low.
- Reset mid-read: assert rst during WAIT_DONE → enables 0 immediately, arb_idle = 1, no rsp_valid; the port re-requests and completes normally.
- Timeout (SDRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16): controller never raises busy → after 16 cycles rsp_valid with rsp_err = 1 and enables 0.
